// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the cache subsystem memory arbiter.
package arm7tdmi_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam int unsigned ARB_MAX_BEATS = 8;
    // One extra bit so a full 8-beat burst count does not wrap.
    localparam int unsigned ARB_CNT_W     = $clog2(ARB_MAX_BEATS) + 1;

endpackage

// File: rtl/arm7tdmi_cache_mem_arbiter.sv
// External memory port arbiter: D-cache has fixed priority, I-cache is protected
// from starvation and held off during coherency invalidation. Whole bursts only.
module arm7tdmi_cache_mem_arbiter
    import arm7tdmi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_burst_len,
    output logic                  i_gnt,
    output logic [31:0]           i_rdata,
    output logic                  i_rvalid,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [2:0]            d_burst_len,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_byte_en,
    output logic                  d_gnt,
    output logic [31:0]           d_rdata,
    output logic                  d_rvalid,
    output logic                  d_done,
    input  logic                  coh_busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [2:0]            mem_burst_len,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_byte_en,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_valid,
    input  logic                  mem_ready
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arb_state_t            state_q, state_d;
    arb_owner_t            owner_q, pick_own;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            len_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;
    logic [ARB_CNT_W-1:0]  issued_q, issued_d, returned_q, returned_d, beats;
    logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
    logic                  i_elig, starved, grant, xfer;

    // D wins unless an eligible I has already waited out the starvation limit.
    function automatic arb_owner_t pick(input logic d, input logic ie, input logic st);
        arb_owner_t own;
        own = OWN_NONE;
        if (d && ie)  own = st ? OWN_I : OWN_D;
        else if (d)   own = OWN_D;
        else if (ie)  own = OWN_I;
        return own;
    endfunction

    assign i_elig   = i_req & ~coh_busy;
    assign starved  = (starve_cnt_q >= SW'(STARVE_LIMIT));
    assign pick_own = pick(d_req, i_elig, starved);
    assign grant    = (state_q == ARB_IDLE) && (pick_own != OWN_NONE);
    assign beats    = ARB_CNT_W'(len_q) + ARB_CNT_W'(1);
    assign xfer     = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: issue until all beats accepted, wait until all beats returned.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (pick_own != OWN_NONE) state_d = ARB_ISSUE;
            ARB_ISSUE: begin
                if (returned_q == beats)     state_d = ARB_DONE;
                else if (issued_d == beats)  state_d = ARB_WAIT;
            end
            ARB_WAIT:  if (returned_q == beats) state_d = ARB_DONE;
            ARB_DONE:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Beat and starvation counter next-state.
    always_comb begin
        issued_d     = issued_q;
        returned_d   = returned_q;
        starve_cnt_d = starve_cnt_q;
        if (grant) begin
            issued_d   = '0;
            returned_d = '0;
        end else begin
            if ((state_q == ARB_ISSUE) && mem_ready) issued_d = issued_q + ARB_CNT_W'(1);
            if (xfer && mem_valid)                   returned_d = returned_q + ARB_CNT_W'(1);
        end
        if (state_q == ARB_IDLE) begin
            if (!i_elig || (pick_own == OWN_I))   starve_cnt_d = '0;
            else if ((pick_own == OWN_D) && !starved) starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q     <= '0;
            returned_q   <= '0;
            starve_cnt_q <= '0;
        end else begin
            issued_q     <= issued_d;
            returned_q   <= returned_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Capture the winning request's fields on grant; release ownership after DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            write_q <= 1'b0;
            len_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (grant) begin
            owner_q <= pick_own;
            if (pick_own == OWN_D) begin
                addr_q  <= d_addr;
                write_q <= d_write;
                len_q   <= d_write ? 3'd0 : d_burst_len;
                wdata_q <= d_wdata;
                be_q    <= d_byte_en;
            end else begin
                addr_q  <= i_addr;
                write_q <= 1'b0;
                len_q   <= i_burst_len;
                wdata_q <= '0;
                be_q    <= '0;
            end
        end else if (state_q == ARB_DONE) begin
            owner_q <= OWN_NONE;
        end
    end

    // Outputs: grant while busy, memory request in ISSUE, response routed to owner.
    always_comb begin
        i_gnt         = 1'b0;
        i_rdata       = '0;
        i_rvalid      = 1'b0;
        i_done        = 1'b0;
        d_gnt         = 1'b0;
        d_rdata       = '0;
        d_rvalid      = 1'b0;
        d_done        = 1'b0;
        mem_addr      = '0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        mem_burst_len = '0;
        mem_wdata     = '0;
        mem_byte_en   = '0;
        if (state_q != ARB_IDLE) begin
            i_gnt = (owner_q == OWN_I);
            d_gnt = (owner_q == OWN_D);
        end
        if (state_q == ARB_ISSUE) begin
            mem_req       = 1'b1;
            mem_addr      = addr_q;
            mem_write     = write_q;
            mem_burst_len = len_q;
            mem_wdata     = wdata_q;
            mem_byte_en   = be_q;
        end
        if (xfer && (owner_q == OWN_I)) begin
            i_rdata  = mem_rdata;
            i_rvalid = mem_valid & ~write_q;
        end
        if (xfer && (owner_q == OWN_D)) begin
            d_rdata  = mem_rdata;
            d_rvalid = mem_valid & ~write_q;
        end
        if (state_q == ARB_DONE) begin
            i_done = (owner_q == OWN_I);
            d_done = (owner_q == OWN_D);
        end
    end

endmodule

// File: tb/tb_arm7tdmi_cache_mem_arbiter.sv
// Scoreboard bench for the cache memory arbiter with a 1-cycle memory model.
module tb_arm7tdmi_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req, d_req, d_write, coh_busy, mem_valid, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  i_burst_len, d_burst_len;
    logic [3:0]  d_byte_en;
    logic        i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_write;
    logic [2:0]  mem_burst_len;
    logic [3:0]  mem_byte_en;
    logic [142:0] all_outs;

    arm7tdmi_cache_mem_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_burst_len(i_burst_len),
        .i_gnt(i_gnt), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_burst_len(d_burst_len),
        .d_wdata(d_wdata), .d_byte_en(d_byte_en),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .coh_busy(coh_busy),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_write(mem_write),
        .mem_burst_len(mem_burst_len), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready)
    );

    assign all_outs = {i_gnt, i_rdata, i_rvalid, i_done, d_gnt, d_rdata, d_rvalid, d_done,
                       mem_addr, mem_req, mem_write, mem_burst_len, mem_wdata, mem_byte_en};

    always #5 clk = ~clk;

    typedef struct packed {
        logic        side;     // 0 = I, 1 = D
        logic        is_done;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  i_rv_seen = 0;
    int  d_rv_seen = 0;

    // Memory model: word w holds w*4 unless written.
    logic [31:0] mem_wr  [0:4095];
    logic        wr_vld  [0:4095];
    logic [3:0]  bidx;

    function automatic logic [31:0] rd(input logic [31:0] w);
        if (wr_vld[w[11:0]]) return mem_wr[w[11:0]];
        return {w[29:0], 2'b00};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = be[k] ? n[k*8 +: 8] : o[k*8 +: 8];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_rdata <= 32'h0;
            bidx      <= 4'd0;
            for (int k = 0; k < 4096; k++) wr_vld[k] <= 1'b0;
        end else begin
            mem_valid <= 1'b0;
            mem_rdata <= 32'h0;
            if (mem_req && mem_ready) begin
                bidx      <= bidx + 4'd1;
                mem_valid <= 1'b1;
                if (mem_write) begin
                    mem_wr[12'(mem_addr[13:2] + 12'(bidx))] <=
                        merge(rd((mem_addr >> 2) + 32'(bidx)), mem_wdata, mem_byte_en);
                    wr_vld[12'(mem_addr[13:2] + 12'(bidx))] <= 1'b1;
                end else begin
                    mem_rdata <= rd((mem_addr >> 2) + 32'(bidx));
                end
            end else if (!mem_req) begin
                bidx <= 4'd0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic sb_pop(input logic side, input logic is_done, input logic [31:0] data);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got side=%0d done=%0d data=0x%08h, expected no event",
                     side, is_done, data);
            return;
        end
        e = exp_q.pop_front();
        if (e.side !== side || e.is_done !== is_done || e.data !== data) begin
            fails++;
            $display("FAIL sb_event: got side=%0d done=%0d data=0x%08h, expected side=%0d done=%0d data=0x%08h",
                     side, is_done, data, e.side, e.is_done, e.data);
        end
    endtask

    // Monitor: every response strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_rvalid) begin sb_pop(1'b0, 1'b0, i_rdata); i_rv_seen++; end
            if (i_done)   sb_pop(1'b0, 1'b1, 32'h0);
            if (d_rvalid) begin sb_pop(1'b1, 1'b0, d_rdata); d_rv_seen++; end
            if (d_done)   sb_pop(1'b1, 1'b1, 32'h0);
        end
    end

    task automatic push_ev(input logic side, input logic is_done, input logic [31:0] data);
        ev_t e;
        e.side = side; e.is_done = is_done; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_read(input logic side, input logic [31:0] addr, input int beats,
                             input logic with_done);
        for (int b = 0; b < beats; b++) push_ev(side, 1'b0, rd((addr >> 2) + 32'(b)));
        if (with_done) push_ev(side, 1'b1, 32'h0);
    endtask

    task automatic wait_done(input logic side, input int budget, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            seen = side ? d_done : i_done;
        end
        check(side ? "d_done_seen" : "i_done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    int n, bad, bad2, cyc, c2, base;

    initial begin
        i_req = 0; i_addr = 0; i_burst_len = 0;
        d_req = 0; d_write = 0; d_addr = 0; d_burst_len = 0; d_wdata = 0; d_byte_en = 0;
        coh_busy = 0; mem_ready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check("rst_outs_low", 64'(|all_outs), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_outs_low", 64'(|all_outs), 64'd0);
        check("post_rst_starve", 64'(dut.starve_cnt_q), 64'd0);

        // T1: lone 8-beat I refill
        push_read(1'b0, 32'h1000, 8, 1'b1);
        i_addr = 32'h1000; i_burst_len = 3'd7; i_req = 1;
        @(posedge clk); #1;
        check("t1_i_gnt", 64'(i_gnt), 64'd1);
        check("t1_d_gnt", 64'(d_gnt), 64'd0);
        check("t1_mem_len", 64'(mem_burst_len), 64'd7);
        n = 0; bad = 0; cyc = 0;
        while (mem_req && n < 20) begin
            n++;
            if (mem_addr !== 32'h1000) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        check("t1_req_cycles", 64'(n), 64'd8);
        check("t1_addr_held", 64'(bad), 64'd0);
        wait_done(1'b0, 20, c2);
        i_req = 0;
        check("t1_done_latency", 64'(cyc + c2), 64'd10);

        // T2: simultaneous I and D, D first, I after one IDLE bubble
        @(posedge clk); #1;
        push_read(1'b1, 32'h3000, 4, 1'b1);
        push_read(1'b0, 32'h2000, 2, 1'b1);
        d_addr = 32'h3000; d_burst_len = 3'd3; d_write = 0; d_req = 1;
        i_addr = 32'h2000; i_burst_len = 3'd1; i_req = 1;
        @(posedge clk); #1;
        check("t2_d_gnt", 64'(d_gnt), 64'd1);
        check("t2_i_gnt_low", 64'(i_gnt), 64'd0);
        check("t2_mem_addr", 64'(mem_addr), 64'h3000);
        wait_done(1'b1, 30, c2);
        d_req = 0;
        check("t2_d_done_latency", 64'(c2), 64'd6);
        @(posedge clk); #1;
        check("t2_bubble", 64'(i_gnt | d_gnt | mem_req), 64'd0);
        @(posedge clk); #1;
        check("t2_i_gnt", 64'(i_gnt), 64'd1);
        check("t2_i_mem_addr", 64'(mem_addr), 64'h2000);
        wait_done(1'b0, 30, c2);
        i_req = 0;

        // T3: D write, burst length forced to zero, no read strobes
        @(posedge clk); #1;
        push_ev(1'b1, 1'b1, 32'h0);
        base = d_rv_seen;
        d_write = 1; d_addr = 32'h1000; d_wdata = 32'hE3A00042; d_byte_en = 4'hF;
        d_burst_len = 3'd5; d_req = 1;
        @(posedge clk); #1;
        check("t3_mem_write", 64'(mem_write), 64'd1);
        check("t3_mem_len", 64'(mem_burst_len), 64'd0);
        check("t3_mem_wdata", 64'(mem_wdata), 64'hE3A00042);
        check("t3_mem_be", 64'(mem_byte_en), 64'hF);
        n = 0;
        while (mem_req && n < 20) begin n++; @(posedge clk); #1; end
        check("t3_req_cycles", 64'(n), 64'd1);
        wait_done(1'b1, 20, c2);
        d_req = 0; d_write = 0;
        check("t3_no_rvalid", 64'(d_rv_seen - base), 64'd0);
        check("t3_mem_word", 64'(rd(32'h400)), 64'hE3A00042);

        // T4: D re-requests continuously while I waits: 4 D grants then I
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) push_read(1'b1, 32'h800 + 32'(16 * k), 1, 1'b1);
        push_read(1'b0, 32'h400, 1, 1'b1);
        push_read(1'b1, 32'h840, 1, 1'b1);
        fork
            begin
                int ci;
                i_addr = 32'h400; i_burst_len = 3'd0; i_req = 1;
                wait_done(1'b0, 200, ci);
                i_req = 0;
                check("t4_starve_after_i", 64'(dut.starve_cnt_q), 64'd0);
            end
            begin
                int cd;
                for (int k = 0; k < 5; k++) begin
                    d_addr = 32'h800 + 32'(16 * k); d_burst_len = 3'd0; d_req = 1;
                    wait_done(1'b1, 200, cd);
                    d_req = 0;
                    if (k == 3) check("t4_starve_at_limit", 64'(dut.starve_cnt_q), 64'd4);
                    if (k < 4) begin @(posedge clk); #1; end
                end
            end
        join
        check("t4_starve_end", 64'(dut.starve_cnt_q), 64'd0);

        // T5: coherency busy blocks I, grant follows the cycle after it falls
        @(posedge clk); #1;
        push_read(1'b0, 32'h600, 2, 1'b1);
        coh_busy = 1; i_addr = 32'h600; i_burst_len = 3'd1; i_req = 1;
        bad = 0; bad2 = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (i_gnt) bad++;
            if (dut.starve_cnt_q != 0) bad2++;
        end
        check("t5_no_gnt", 64'(bad), 64'd0);
        check("t5_starve_zero", 64'(bad2), 64'd0);
        coh_busy = 0;
        @(posedge clk); #1;
        check("t5_i_gnt", 64'(i_gnt), 64'd1);
        wait_done(1'b0, 20, c2);
        i_req = 0;

        // T6: reset after beat 3 of an 8-beat refill, then normal service
        @(posedge clk); #1;
        push_read(1'b0, 32'h2000, 3, 1'b0);
        base = i_rv_seen;
        i_addr = 32'h2000; i_burst_len = 3'd7; i_req = 1;
        n = 0;
        while ((i_rv_seen - base) < 3 && n < 40) begin @(negedge clk); #1; n++; end
        check("t6_beats_before_rst", 64'(i_rv_seen - base), 64'd3);
        rst_n = 1'b0;
        #1;
        check("t6_outs_low", 64'(|all_outs), 64'd0);
        i_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_idle_after_rst", 64'(|all_outs), 64'd0);
        push_read(1'b0, 32'h2000, 2, 1'b1);
        i_addr = 32'h2000; i_burst_len = 3'd1; i_req = 1;
        @(posedge clk); #1;
        check("t6_i_gnt", 64'(i_gnt), 64'd1);
        wait_done(1'b0, 20, c2);
        i_req = 0;

        repeat (3) @(posedge clk);
        #1 check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
